// File: rtl/atm_controlador_param.sv
// ATM session controller: card detect, serial PIN check with attempt
// lockout, one deposit or withdrawal per session, foreign-card fee,
// inactivity timeout and saturating deposits.
module atm_controlador_param #(
   parameter int unsigned PIN_DIGITS      = 4,
   parameter int unsigned DIGIT_W         = 4,
   parameter int unsigned BAL_W           = 64,
   parameter int unsigned MONTO_W         = 32,
   parameter int unsigned MAX_INTENTOS    = 3,
   parameter int unsigned TIMEOUT_CYC     = 1000,
   parameter int unsigned COMISION        = 2,
   parameter logic [63:0] BALANCE_INICIAL = 64'd1000
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_tarjeta_recibida,
   input  logic                          i_tipo_de_tarjeta,
   input  logic [PIN_DIGITS*DIGIT_W-1:0] i_pin,
   input  logic [DIGIT_W-1:0]            i_digito,
   input  logic                          i_digito_stb,
   input  logic                          i_tipo_trans,
   input  logic [MONTO_W-1:0]            i_monto,
   input  logic                          i_monto_stb,
   output logic [BAL_W-1:0]              o_balance,
   output logic                          o_balance_actualizado,
   output logic                          o_entregar_dinero,
   output logic                          o_fondos_insuficientes,
   output logic                          o_pin_incorrecto,
   output logic                          o_advertencia,
   output logic                          o_bloqueo
);

   localparam int unsigned PIN_W = PIN_DIGITS * DIGIT_W;
   localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);
   localparam int unsigned ATT_W = $clog2(MAX_INTENTOS + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned EXT_W = BAL_W + 1;

   typedef enum logic [2:0] {
      S_ESPERA  = 3'd0,
      S_PIN     = 3'd1,
      S_TRANS   = 3'd2,
      S_FIN     = 3'd3,
      S_BLOQUEO = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [PIN_W-1:0]   r_shift, w_shift_nxt;
   logic [ATT_W-1:0]   r_att, w_att_nxt;
   logic [TO_W-1:0]    r_to, w_to_nxt;
   logic [BAL_W-1:0]   r_bal, w_bal_nxt;
   logic               r_act, w_act_nxt;
   logic               r_ent, w_ent_nxt;
   logic               r_fon, w_fon_nxt;
   logic               r_pinc, w_pinc_nxt;
   logic               r_adv, w_adv_nxt;
   logic               r_blo, w_blo_nxt;

   logic               w_dig_acc, w_mon_acc, w_stb_acc, w_last, w_match;
   logic               w_timeout, w_in_session;
   logic [PIN_W-1:0]   w_shift_in;
   logic [ATT_W-1:0]   w_att_inc;
   logic [EXT_W-1:0]   w_sum, w_cost;

   // Strobe qualification, PIN compare and arithmetic shared by both comb blocks
   always_comb begin
      w_in_session = (r_state == S_PIN) || (r_state == S_TRANS);
      w_dig_acc    = (r_state == S_PIN)   && i_tarjeta_recibida && i_digito_stb;
      w_mon_acc    = (r_state == S_TRANS) && i_tarjeta_recibida && i_monto_stb;
      w_stb_acc    = w_dig_acc || w_mon_acc;
      w_last       = w_dig_acc && (r_cnt == CNT_W'(PIN_DIGITS - 1));
      w_shift_in   = PIN_W'({r_shift, i_digito});
      w_match      = (w_shift_in == i_pin);
      w_att_inc    = r_att + ATT_W'(1);
      w_timeout    = w_in_session && i_tarjeta_recibida && !w_stb_acc &&
                     (r_to == TO_W'(TIMEOUT_CYC - 1));
      w_sum        = {1'b0, r_bal} + EXT_W'(i_monto);
      w_cost       = EXT_W'(i_monto) + (i_tipo_de_tarjeta ? EXT_W'(0) : EXT_W'(COMISION));
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_ESPERA;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_ESPERA: if (i_tarjeta_recibida) w_state_nxt = S_PIN;
         S_PIN: begin
            if (!i_tarjeta_recibida)                                   w_state_nxt = S_ESPERA;
            else if (w_last && w_match)                                w_state_nxt = S_TRANS;
            else if (w_last && (w_att_inc == ATT_W'(MAX_INTENTOS)))    w_state_nxt = S_BLOQUEO;
            else if (w_timeout)                                        w_state_nxt = S_FIN;
         end
         S_TRANS: begin
            if (!i_tarjeta_recibida)       w_state_nxt = S_ESPERA;
            else if (w_mon_acc || w_timeout) w_state_nxt = S_FIN;
         end
         S_FIN:     if (!i_tarjeta_recibida) w_state_nxt = S_ESPERA;
         S_BLOQUEO: w_state_nxt = S_BLOQUEO;
         default:   w_state_nxt = S_ESPERA;
      endcase
   end

   // Next values of datapath registers and registered outputs
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_att_nxt   = r_att;
      w_adv_nxt   = r_adv;
      w_blo_nxt   = r_blo;
      w_bal_nxt   = r_bal;
      w_act_nxt   = 1'b0;
      w_ent_nxt   = 1'b0;
      w_fon_nxt   = 1'b0;
      w_pinc_nxt  = 1'b0;
      w_to_nxt    = '0;
      case (r_state)
         S_ESPERA: begin
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
         end
         S_PIN: begin
            if (!i_tarjeta_recibida) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = '0;
            end else if (w_dig_acc) begin
               w_shift_nxt = w_shift_in;
               if (w_last) begin
                  w_cnt_nxt = '0;
                  if (w_match) begin
                     w_att_nxt = '0;
                     w_adv_nxt = 1'b0;
                  end else begin
                     w_pinc_nxt = 1'b1;
                     w_att_nxt  = w_att_inc;
                     if (w_att_inc == ATT_W'(MAX_INTENTOS - 1)) w_adv_nxt = 1'b1;
                     if (w_att_inc == ATT_W'(MAX_INTENTOS))     w_blo_nxt = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         S_TRANS: begin
            if (w_mon_acc) begin
               if (i_tipo_trans) begin
                  w_bal_nxt = w_sum[BAL_W] ? '1 : w_sum[BAL_W-1:0];
                  w_act_nxt = 1'b1;
               end else if (w_cost <= {1'b0, r_bal}) begin
                  w_bal_nxt = r_bal - BAL_W'(w_cost);
                  w_act_nxt = 1'b1;
                  w_ent_nxt = 1'b1;
               end else begin
                  w_fon_nxt = 1'b1;
               end
            end
         end
         default: ;
      endcase
      // Idle counter restarts on state entry and on every accepted strobe
      if (w_in_session && (w_state_nxt == r_state) && !w_stb_acc)
         w_to_nxt = r_to + TO_W'(1);
   end

   // Datapath and output registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_att   <= '0;
         r_to    <= '0;
         r_bal   <= BAL_W'(BALANCE_INICIAL);
         r_act   <= 1'b0;
         r_ent   <= 1'b0;
         r_fon   <= 1'b0;
         r_pinc  <= 1'b0;
         r_adv   <= 1'b0;
         r_blo   <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_att   <= w_att_nxt;
         r_to    <= w_to_nxt;
         r_bal   <= w_bal_nxt;
         r_act   <= w_act_nxt;
         r_ent   <= w_ent_nxt;
         r_fon   <= w_fon_nxt;
         r_pinc  <= w_pinc_nxt;
         r_adv   <= w_adv_nxt;
         r_blo   <= w_blo_nxt;
      end
   end

   assign o_balance              = r_bal;
   assign o_balance_actualizado  = r_act;
   assign o_entregar_dinero      = r_ent;
   assign o_fondos_insuficientes = r_fon;
   assign o_pin_incorrecto       = r_pinc;
   assign o_advertencia          = r_adv;
   assign o_bloqueo              = r_blo;

endmodule

// File: tb/tb_atm_controlador_param.sv
// Scoreboard bench for atm_controlador_param: stimulus queues expected
// result pulses, an independent monitor pops and checks each one.
module tb_atm_controlador_param;

   localparam int unsigned TO = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        card, own;
   logic [15:0] pin;
   logic [3:0]  digito;
   logic        digito_stb;
   logic        tipo_trans;
   logic [15:0] monto;
   logic        monto_stb;
   logic [15:0] balance;
   logic        act, ent, fon, pinc, adv, blo;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int unsigned cyc;
      logic        act, ent, fon, pinc, adv, blo;
      logic [15:0] bal;
   } exp_t;

   exp_t q[$];

   atm_controlador_param #(
      .PIN_DIGITS(4), .DIGIT_W(4), .BAL_W(16), .MONTO_W(16),
      .MAX_INTENTOS(3), .TIMEOUT_CYC(TO), .COMISION(2),
      .BALANCE_INICIAL(64'd1000)
   ) dut (
      .i_clk(clk), .i_reset(reset),
      .i_tarjeta_recibida(card), .i_tipo_de_tarjeta(own), .i_pin(pin),
      .i_digito(digito), .i_digito_stb(digito_stb),
      .i_tipo_trans(tipo_trans), .i_monto(monto), .i_monto_stb(monto_stb),
      .o_balance(balance), .o_balance_actualizado(act),
      .o_entregar_dinero(ent), .o_fondos_insuficientes(fon),
      .o_pin_incorrecto(pinc), .o_advertencia(adv), .o_bloqueo(blo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every result pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (act || ent || fon || pinc) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d act=%b ent=%b fon=%b pinc=%b bal=%0d",
                     cyc, act, ent, fon, pinc, balance);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc || e.act != act || e.ent != ent || e.fon != fon ||
                e.pinc != pinc || e.adv != adv || e.blo != blo || e.bal != balance) begin
               errors++;
               $display("FAIL event got cyc=%0d act=%b ent=%b fon=%b pinc=%b adv=%b blo=%b bal=%0d expected cyc=%0d act=%b ent=%b fon=%b pinc=%b adv=%b blo=%b bal=%0d",
                        cyc, act, ent, fon, pinc, adv, blo, balance,
                        e.cyc, e.act, e.ent, e.fon, e.pinc, e.adv, e.blo, e.bal);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end
   endtask

   // Queue an expected result that appears one cycle after the strobe driven now
   task automatic push(input logic a, input logic en, input logic f, input logic p,
                       input logic ad, input logic bl, input logic [15:0] b);
      exp_t e;
      e.cyc = cyc + 1; e.act = a; e.ent = en; e.fon = f; e.pinc = p;
      e.adv = ad; e.blo = bl; e.bal = b;
      q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1; card = 1'b0; own = 1'b1; digito = '0; digito_stb = 1'b0;
      tipo_trans = 1'b0; monto = '0; monto_stb = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start_session(input logic own_card);
      card = 1'b1; own = own_card;
      @(negedge clk);
   endtask

   task automatic end_session();
      card = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_digit(input logic [3:0] d);
      digito = d; digito_stb = 1'b1;
      @(negedge clk);
      digito_stb = 1'b0;
   endtask

   // Enter four digits; optionally expect a pin_incorrecto result on the last
   task automatic enter_pin(input logic [15:0] p, input bit ev, input logic ad,
                            input logic bl, input logic [15:0] b);
      logic [15:0] v;
      v = p;
      for (int i = 3; i >= 0; i--) begin
         if (i == 0 && ev) push(1'b0, 1'b0, 1'b0, 1'b1, ad, bl, b);
         send_digit(v[i*4 +: 4]);
      end
   endtask

   task automatic do_trans(input logic dep, input logic [15:0] m, input bit ev,
                           input logic a, input logic en, input logic f,
                           input logic ad, input logic [15:0] b);
      tipo_trans = dep; monto = m;
      if (ev) push(a, en, f, 1'b0, ad, 1'b0, b);
      monto_stb = 1'b1;
      @(negedge clk);
      monto_stb = 1'b0;
   endtask

   initial begin
      pin = 16'h1234;
      do_reset();
      chk("reset_balance", 32'(balance), 32'd1000);
      chk("reset_adv", 32'(adv), 32'd0);
      chk("reset_blo", 32'(blo), 32'd0);
      chk("reset_pulses", 32'({act, ent, fon, pinc}), 32'd0);

      // 1: own card deposit; a second strobe in FIN is ignored
      start_session(1'b1);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b1, 16'd500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1500);
      do_trans(1'b1, 16'd500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      end_session();
      chk("t1_balance", 32'(balance), 32'd1500);

      // 2: foreign card, cost equals balance exactly, then insufficient funds
      do_reset();
      start_session(1'b0);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b0, 16'd998, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
      end_session();
      start_session(1'b0);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      end_session();

      // 3: warning after second failure, lockout on third (attempts survive card pull)
      do_reset();
      start_session(1'b1);
      enter_pin(16'h1235, 1'b1, 1'b0, 1'b0, 16'd1000);
      enter_pin(16'h9999, 1'b1, 1'b1, 1'b0, 16'd1000);
      chk("t3_adv_level", 32'(adv), 32'd1);
      end_session();
      start_session(1'b1);
      enter_pin(16'h0000, 1'b1, 1'b1, 1'b1, 16'd1000);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b1, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      end_session();
      start_session(1'b1);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b1, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk("t3_blo_level", 32'(blo), 32'd1);
      chk("t3_balance", 32'(balance), 32'd1000);
      do_reset();
      chk("t3_reset_blo", 32'(blo), 32'd0);
      chk("t3_reset_adv", 32'(adv), 32'd0);

      // 4: partial digits discarded on card pull; long idle below timeout still OK
      start_session(1'b1);
      send_digit(4'h1);
      send_digit(4'h2);
      end_session();
      start_session(1'b1);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      repeat (TO - 3) @(negedge clk);
      do_trans(1'b1, 16'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1010);
      end_session();
      // card removal beats a simultaneous monto strobe
      start_session(1'b1);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      card = 1'b0;
      do_trans(1'b1, 16'd77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      start_session(1'b1);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b1, 16'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1015);
      end_session();

      // 5: deposit saturation
      do_reset();
      start_session(1'b1);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b1, 16'd64525, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd65525);
      end_session();
      start_session(1'b1);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b1, 16'd50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
      end_session();

      // 6: inactivity timeout sends session to FIN; strobes then ignored
      do_reset();
      start_session(1'b1);
      repeat (TO + 3) @(negedge clk);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk("t6_balance_after_timeout", 32'(balance), 32'd1000);
      end_session();
      start_session(1'b1);
      enter_pin(16'h1234, 1'b0, 1'b0, 1'b0, 16'd0);
      do_trans(1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1001);
      end_session();

      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      while (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         $display("FAIL missing_event expected_cyc=%0d bal=%0d", e.cyc, e.bal);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
